// File: rtl/serial_rx_if.sv
// Link-side bundle for the serial receiver: the incoming bit stream with its
// qualifiers, plus the reassembled word and status flags going back out.
interface serial_rx_if #(
    parameter int WIDTH = 16
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic             in;
    logic             in_valid;
    logic             frame_start;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             busy;
    logic             frame_err;
    logic [CW-1:0]    bit_count;

    // Driver side: the link/transmitter feeding bits and watching results.
    modport master (
        output in, in_valid, frame_start,
        input  out, out_valid, busy, frame_err, bit_count
    );

    // Receiver side.
    modport slave (
        input  in, in_valid, frame_start,
        output out, out_valid, busy, frame_err, bit_count
    );
endinterface

// File: rtl/serial_rx.sv
// Serial link receiver: reassembles an MSB-first bit stream into WIDTH-bit
// words. frame_start marks bit 0 of a word; a frame_start arriving mid-word
// resyncs onto the new word and flags the discarded partial word. An optional
// stall timeout aborts words whose transmitter went quiet.
module serial_rx #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 0
) (
    input logic        clk,
    input logic        reset,
    serial_rx_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    // Counter only has to reach TIMEOUT; it is cleared on reaching it.
    localparam int SW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SW-1:0]    stall_q, stall_d, stall_inc;
    logic [WIDTH-1:0] out_q, out_d;
    logic             ov_q, ov_d;
    logic             fe_q, fe_d;

    // State and datapath registers; reset drops any partial word silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            stall_q <= '0;
            out_q   <= '0;
            ov_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            out_q   <= out_d;
            ov_q    <= ov_d;
            fe_q    <= fe_d;
        end
    end

    // Next-state logic: accept/shift bits, complete words, resync and timeout.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        stall_d   = stall_q;
        out_d     = out_q;
        ov_d      = 1'b0;
        fe_d      = 1'b0;
        stall_inc = stall_q + SW'(1);

        case (state_q)
            IDLE: begin
                // Bits without frame_start are line noise between words.
                stall_d = '0;
                if (bus.in_valid && bus.frame_start) begin
                    shift_d = {{(WIDTH-1){1'b0}}, bus.in};
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.in_valid) begin
                    stall_d = '0;
                    if (bus.frame_start) begin
                        // Resync: drop the partial word, this bit is the new MSB.
                        fe_d    = 1'b1;
                        shift_d = {{(WIDTH-1){1'b0}}, bus.in};
                        cnt_d   = CW'(1);
                    end else begin
                        shift_d = {shift_q[WIDTH-2:0], bus.in};
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            // Last bit: publish on this same edge so the next
                            // frame_start can follow with no gap.
                            out_d   = shift_d;
                            ov_d    = 1'b1;
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end else if (TIMEOUT > 0) begin
                    if (stall_inc == SW'(TIMEOUT)) begin
                        fe_d    = 1'b1;
                        cnt_d   = '0;
                        stall_d = '0;
                        state_d = IDLE;
                    end else begin
                        stall_d = stall_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.out       = out_q;
    assign bus.out_valid = ov_q;
    assign bus.frame_err = fe_q;
    assign bus.bit_count = cnt_q;
    assign bus.busy      = (state_q == SHIFT);

endmodule

// File: doc/serial_rx.md
Name: serial_rx

Overview:
- Receiving end of the team's mux-based serial link. The transmitter time-multiplexes one word onto a single wire, MSB first. This block demultiplexes that bit stream back into a parallel word.
- Sits between the single-bit link wire and word-wide consumers (register, RAM or CPU input).
- Adds framing, stall handling, error detection and a timeout on top of a shift register and bit counter.

Parameters:
- WIDTH, 16, word width in bits; legal range 2..32.
- TIMEOUT, 0, maximum consecutive stall cycles (in_valid low) allowed mid-word before abort; 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in  input  1  serial data bit.
- in_valid  input  1  in is valid this cycle.
- frame_start  input  1  qualifies in as bit 0 (MSB) of a new word; meaningful only when in_valid=1.
- out  output  WIDTH  last completed word.
- out_valid  output  1  one-cycle pulse: out was updated this cycle.
- busy  output  1  high while a word is partially received.
- frame_err  output  1  one-cycle pulse: a partial word was discarded.
- bit_count  output  clog2(WIDTH)+1  bits accepted so far in the current word.

Behaviour:
- Reset: all registers clear synchronously.
  - out=0, out_valid=0, busy=0, frame_err=0, bit_count=0, stall counter=0, state=IDLE.
  - Reset asserted mid-word discards the partial word with no frame_err pulse.
- A bit is accepted on a rising edge where in_valid=1 and the conditions below hold. Ordering is MSB first: shift_reg <= {shift_reg[WIDTH-2:0], in}.
- State IDLE:
  - in_valid=1 and frame_start=1: load shift_reg with in, bit_count=1, go to SHIFT.
  - in_valid=1 and frame_start=0: bit ignored, no error, state unchanged.
- State SHIFT, in_valid=1 and frame_start=0:
  - Shift the bit in and increment bit_count; clear the stall counter.
  - If this was bit WIDTH (bit_count was WIDTH-1): on the same edge, out <= the assembled word, out_valid=1, bit_count=0, state IDLE.
- State SHIFT, in_valid=1 and frame_start=1 (resync):
  - frame_err=1; the partial word is discarded.
  - The current bit becomes bit 0 of a new word: bit_count=1, stay in SHIFT.
- State SHIFT, in_valid=0:
  - Hold shift_reg and bit_count; increment the stall counter.
  - If TIMEOUT>0 and the stall counter reaches TIMEOUT: frame_err=1, bit_count=0, state IDLE, stall counter cleared.
- busy = (state==SHIFT), registered.
- Latency:
  - out/out_valid are visible in the cycle after the edge that sampled the last bit.
  - out holds its value until the next completed word; out_valid is low except for that single cycle.
- Back-to-back words: frame_start in the cycle directly after the last bit is accepted, giving a zero-gap stream. Sustained throughput is 1 word per WIDTH cycles.
- Partial words never modify out.
- frame_err and out_valid are never high in the same cycle.

Test Plan:
- WIDTH=16: frame_start+in_valid on bit 0, then 15 more bits of 0xA5C3 MSB first, in_valid held high -> out=16'hA5C3, out_valid high for exactly 1 cycle (the cycle after the 16th bit), busy falls in the same cycle.
- Two words 0x0001 then 0xFFFF, sent with no gap -> two out_valid pulses 16 cycles apart; out=0x0001 then 0xFFFF; frame_err never asserts.
- Send 0x1234 with in_valid dropped for 3 cycles after bit 5 and again after bit 11, TIMEOUT=0 -> out=0x1234, bit_count holds at 6 and 12 during the stalls.
- After 7 bits, assert frame_start with a new word 0xBEEF -> frame_err pulses 1 cycle; out=0xBEEF after 16 further bits; out is unchanged from the previous value until then.
- TIMEOUT=4, send 3 bits, then in_valid low for 4 cycles -> frame_err pulse after the 4th stall cycle; busy=0, bit_count=0; a subsequent full word 0x00FF is received correctly.
- Assert reset after 10 bits of a word -> the next cycle shows out=0, busy=0, bit_count=0, no frame_err; in_valid bits without frame_start are then ignored (out_valid stays low).
